// File: rtl/seq_array_multiplier.sv
// Iterative shift-and-add WIDTH x WIDTH multiplier with start/busy/done handshake.
// One partial-product row of the latched multiplier is accumulated per clock.
module seq_array_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               signed_mode_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             signed_q;
  logic [CntW-1:0]  cnt_q;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    p_q;
  logic             busy_q, done_q;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    addend;
  logic             last;

  // In signed mode the top multiplier bit carries weight -2^(W-1), so its row is subtracted.
  always_comb begin
    a_ext  = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    addend = a_ext << cnt_q;
    last   = (cnt_q == CntW'(WIDTH - 1));
    acc_d  = acc_q;
    if (b_q[cnt_q]) begin
      if (signed_q && last) begin
        acc_d = acc_q - addend;
      end else begin
        acc_d = acc_q + addend;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q      <= a_i;
            b_q      <= b_i;
            signed_q <= signed_mode_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StRun;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            p_q     <= acc_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign p_o    = p_q;

endmodule

// File: doc/seq_array_multiplier.md
# seq_array_multiplier

Parametrised iterative shift-and-add multiplier; generalises the team's 4x4 combinational array multiplier to WIDTH x WIDTH operands. It adds signed (two's complement) operation and a start/busy/done handshake, and consumes one partial-product row per clock instead of summing all rows combinationally. It sits in the arithmetic datapath as a small-area multiplier with registered operands and a registered product.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a multiplication; sampled only when busy=0.
- signed_mode  in  1  0 = unsigned operands, 1 = two's complement operands; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse; p holds the new result in this cycle.
- p  out  2*WIDTH  registered product; holds its value until the next operation completes.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: when start=1, latch a, b and signed_mode, clear the accumulator, clear the bit counter (width $clog2(WIDTH), minimum 1), and go to RUN.
- RUN: processes bit i = counter of the latched b, one bit per cycle.
  - Unsigned mode: acc += zero_ext(a) << i when b[i]=1.
  - Signed mode: acc += sign_ext(a) << i for i < WIDTH-1. For i = WIDTH-1, acc -= sign_ext(a) << (WIDTH-1) when b[WIDTH-1]=1.
  - Accumulator is 2*WIDTH bits and arithmetic is modulo 2^(2*WIDTH). The result is exact in both modes, including (-2^(W-1))^2.
  - After bit WIDTH-1, write the final sum to p and go to DONE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
  - start is also accepted in DONE, with the same actions as in IDLE, giving back-to-back operation. The next state is then RUN.
- start while busy=1 is ignored: no queuing and no effect on the current result.
- a, b and signed_mode changes during RUN are ignored.
- p is written only on entry to DONE and is never partially updated.
- Outputs: busy = (state==RUN); done = (state==DONE).

## Timing
- Reset values: busy=0, done=0, p=0; state IDLE, counter 0, accumulator 0, latched operands 0.
- Reset asserted mid-operation aborts immediately and asynchronously: busy, done and p go to 0. The aborted result is never delivered.
- Latency: start is sampled at edge t.
  - busy is high from edge t to edge t+WIDTH (WIDTH cycles).
  - p updates and done rises at edge t+WIDTH.
  - done falls at edge t+WIDTH+1.
- Throughput: one result every WIDTH+1 cycles when start is held high continuously.
- busy and done are never high simultaneously.
- No combinational path from any input to any output.

## Test plan
- Reset, then WIDTH=4, unsigned, a=15, b=15, one-cycle start. Required: busy high 4 cycles, then done pulse 1 cycle with p=0xE1 (225), and p holds 0xE1 afterwards.
- WIDTH=4, signed: (-8)*(-8) gives p=0x40; (-3)*5 gives p=0xF1; 7*(-1) gives p=0xF9; 0*(-8) gives p=0x00. Each check is taken at its done pulse.
- Start pulsed again during RUN with different a and b. Required: ignored, the original product is delivered, and busy/done timing is unchanged. Then start held high continuously. Required: a done pulse every 5 cycles with the correct successive products.
- Assert rst for one cycle at the 2nd RUN cycle of 9*11. Required: busy=0, done=0 and p=0 immediately, no done pulse follows, and the next 3*4 yields p=0x0C after 4 cycles.
- Exhaustive WIDTH=4 sweep: all 256 (a,b) pairs in both modes, compared against a reference model. Spot-check WIDTH=8 unsigned 255*255 giving 0xFE01 after 8 cycles, and signed (-128)*(-128) giving 0x4000.
